// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel output stage: default widths,
// visible-area geometry, the palette-init FSM states and a sync helper.
package vga_pkg;

  localparam int unsigned DEF_NUM_SRC  = 2;
  localparam int unsigned DEF_IDX_W    = 4;
  localparam int unsigned DEF_COLOR_W  = 6;
  localparam int unsigned DEF_CNT_W    = 10;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Idle (deasserted) sync level: an active-low sync idles high.
  function automatic logic sync_idle(input logic active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// Colour palette: 2**IDX_W x COLOR_W, one write port, one synchronous
// read-first read port (same-address write+read returns the old entry).
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata read data
// (registered, valid the cycle after raddr is presented).
module vga_palette_ram
  import vga_pkg::*;
#(
  parameter int unsigned IDX_W   = DEF_IDX_W,
  parameter int unsigned COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [COLOR_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [COLOR_W-1:0] mem_q [DEPTH];
  logic [COLOR_W-1:0] rdata_q;

  // Non-blocking read of mem_q alongside the write gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_pixel_mixer.sv
// Video output stage: picks one of NUM_SRC palette-index renderers (switching
// only at vblank start), looks the index up in a CPU-writable palette that is
// self-initialised after reset, overlays an optional debug border and delays
// the syncs so everything leaves the block aligned, 2 cycles after input.
// Ports: video_clk/reset (sync, active-high); hcount/vcount/active/hsync/vsync
// from the timing generator; src_index/src_valid per source; src_sel_req
// source request; pal_wr_* palette write port; border_en/border_color overlay;
// red/green/blue DAC outputs; hsync_out/vsync_out delayed syncs; active_sel,
// init_done, sel_error (sticky) status; frame_start pulse with pixel (0,0).
module vga_pixel_mixer
  import vga_pkg::*;
#(
  parameter int unsigned NUM_SRC         = DEF_NUM_SRC,
  parameter int unsigned IDX_W           = DEF_IDX_W,
  parameter int unsigned COLOR_W         = DEF_COLOR_W,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  localparam int unsigned SEL_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned CH             = COLOR_W / 3
) (
  input  logic                     video_clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         hcount_in,
  input  logic [CNT_W-1:0]         vcount_in,
  input  logic                     display_active_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic [NUM_SRC*IDX_W-1:0] src_index,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [SEL_W-1:0]         src_sel_req,
  input  logic                     pal_wr_en,
  input  logic [IDX_W-1:0]         pal_wr_addr,
  input  logic [COLOR_W-1:0]       pal_wr_data,
  input  logic                     border_en,
  input  logic [COLOR_W-1:0]       border_color,
  output logic [CH-1:0]            red,
  output logic [CH-1:0]            green,
  output logic [CH-1:0]            blue,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     init_done,
  output logic                     sel_error,
  output logic                     frame_start
);

  localparam logic SYNC_IDLE = sync_idle(SYNC_ACTIVE_LOW);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_err_q, sel_err_d;
  // S1
  logic               run1_q, run1_d;
  logic               act1_q, act1_d;
  logic               ovl1_q, ovl1_d;
  logic [COLOR_W-1:0] ovl_col1_q, ovl_col1_d;
  logic               org1_q, org1_d;
  logic               hs1_q, hs1_d;
  logic               vs1_q, vs1_d;
  // S2
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hs2_q, hs2_d;
  logic               vs2_q, vs2_d;
  logic               fs_q, fs_d;

  logic               pal_we;
  logic [IDX_W-1:0]   pal_waddr;
  logic [COLOR_W-1:0] pal_wdata;
  logic [IDX_W-1:0]   pal_raddr;
  logic [COLOR_W-1:0] pal_rdata;
  logic               vblank_start;
  logic               border_hit;

  // Init FSM: walk every palette address once, then run forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == {IDX_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
    init_done_d = (state_d == ST_RUN);
  end

  // Palette write port: init walk owns it until the FSM reaches RUN.
  always_comb begin
    if (state_q == ST_INIT) begin
      pal_we    = 1'b1;
      pal_waddr = cnt_q;
      pal_wdata = COLOR_W'(cnt_q);
    end else begin
      pal_we    = pal_wr_en;
      pal_waddr = pal_wr_addr;
      pal_wdata = pal_wr_data;
    end
  end

  // Source select latch, updated only on the first vblank pixel.
  always_comb begin
    vblank_start = (hcount_in == '0) && (vcount_in == CNT_W'(V_ACTIVE));
    sel_d        = sel_q;
    sel_err_d    = sel_err_q;
    if (vblank_start) begin
      if (32'(src_sel_req) < NUM_SRC) begin
        sel_d = src_sel_req;
      end else begin
        sel_err_d = 1'b1;
      end
    end
  end

  // S1: the palette is addressed with the not-yet-registered index so its
  // read register lines up with the other S1 flags.
  always_comb begin
    pal_raddr = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (sel_q == SEL_W'(s) && src_valid[s]) begin
        pal_raddr = src_index[s*IDX_W +: IDX_W];
      end
    end
    border_hit = (hcount_in == '0) || (hcount_in == CNT_W'(H_ACTIVE - 1)) ||
                 (vcount_in == '0) || (vcount_in == CNT_W'(V_ACTIVE - 1));
    run1_d     = (state_q == ST_RUN);
    act1_d     = display_active_in;
    ovl1_d     = border_en && border_hit;
    ovl_col1_d = border_color;
    org1_d     = (hcount_in == '0) && (vcount_in == '0);
    hs1_d      = hsync_in;
    vs1_d      = vsync_in;
  end

  // S2: final colour mux; pixels captured during INIT stay black.
  always_comb begin
    if (!run1_q || !act1_q) begin
      rgb_d = '0;
    end else if (ovl1_q) begin
      rgb_d = ovl_col1_q;
    end else begin
      rgb_d = pal_rdata;
    end
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    fs_d  = org1_q;
  end

  always_ff @(posedge video_clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      sel_q       <= '0;
      sel_err_q   <= 1'b0;
      run1_q      <= 1'b0;
      act1_q      <= 1'b0;
      ovl1_q      <= 1'b0;
      ovl_col1_q  <= '0;
      org1_q      <= 1'b0;
      hs1_q       <= SYNC_IDLE;
      vs1_q       <= SYNC_IDLE;
      rgb_q       <= '0;
      hs2_q       <= SYNC_IDLE;
      vs2_q       <= SYNC_IDLE;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      sel_q       <= sel_d;
      sel_err_q   <= sel_err_d;
      run1_q      <= run1_d;
      act1_q      <= act1_d;
      ovl1_q      <= ovl1_d;
      ovl_col1_q  <= ovl_col1_d;
      org1_q      <= org1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      rgb_q       <= rgb_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      fs_q        <= fs_d;
    end
  end

  vga_palette_ram #(
    .IDX_W   (IDX_W),
    .COLOR_W (COLOR_W)
  ) u_palette (
    .clk   (video_clk),
    .we    (pal_we),
    .waddr (pal_waddr),
    .wdata (pal_wdata),
    .raddr (pal_raddr),
    .rdata (pal_rdata)
  );

  assign red         = rgb_q[COLOR_W-1 -: CH];
  assign green       = rgb_q[2*CH-1 -: CH];
  assign blue        = rgb_q[CH-1:0];
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign active_sel  = sel_q;
  assign init_done   = init_done_q;
  assign sel_error   = sel_err_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pixel_mixer.sv
// Directed bench for vga_pixel_mixer with a scoreboard of expected outputs.
// Three sources are used so that an out-of-range select (3) is representable.
module tb_vga_pixel_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic        act, hs, vs;
  logic [11:0] src_index;
  logic [2:0]  src_valid;
  logic [1:0]  sel_req;
  logic        pal_wr_en;
  logic [3:0]  pal_wr_addr;
  logic [5:0]  pal_wr_data;
  logic        border_en;
  logic [5:0]  border_color;
  logic [1:0]  red, green, blue;
  logic        hsync_out, vsync_out;
  logic [1:0]  active_sel;
  logic        init_done, sel_error, frame_start;

  always #5 clk = ~clk;

  vga_pixel_mixer #(.NUM_SRC(3)) dut (
    .video_clk         (clk),
    .reset             (reset),
    .hcount_in         (hcount),
    .vcount_in         (vcount),
    .display_active_in (act),
    .hsync_in          (hs),
    .vsync_in          (vs),
    .src_index         (src_index),
    .src_valid         (src_valid),
    .src_sel_req       (sel_req),
    .pal_wr_en         (pal_wr_en),
    .pal_wr_addr       (pal_wr_addr),
    .pal_wr_data       (pal_wr_data),
    .border_en         (border_en),
    .border_color      (border_color),
    .red               (red),
    .green             (green),
    .blue              (blue),
    .hsync_out         (hsync_out),
    .vsync_out         (vsync_out),
    .active_sel        (active_sel),
    .init_done         (init_done),
    .sel_error         (sel_error),
    .frame_start       (frame_start)
  );

  // Reference state
  logic [5:0] mdl_pal [16];
  bit         mdl_init;
  int         mdl_cnt;
  int         mdl_sel;
  bit         mdl_err;
  logic [8:0] sb [$];   // {rgb, hsync, vsync, frame_start}
  int         checks;
  int         errors;

  localparam logic [8:0] RST_OUT = 9'b000000_1_1_0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the output for the current inputs, advance the
  // reference state, clock the DUT, then compare the oldest expectation.
  task automatic cyc();
    logic [8:0] e;
    logic [3:0] idx;
    logic [5:0] rgb;
    bit         hit;
    if (reset) begin
      sb.delete();
      sb.push_back(RST_OUT);
      sb.push_back(RST_OUT);
      mdl_init = 1'b1;
      mdl_cnt  = 0;
      mdl_sel  = 0;
      mdl_err  = 1'b0;
    end else begin
      idx = src_valid[mdl_sel] ? src_index[mdl_sel*4 +: 4] : 4'd0;
      hit = (hcount == 10'd0) || (hcount == 10'd639) || (vcount == 10'd0) || (vcount == 10'd479);
      if (mdl_init || !act)       rgb = 6'd0;
      else if (border_en && hit)  rgb = border_color;
      else                        rgb = mdl_pal[idx];
      sb.push_back({rgb, hs, vs, (hcount == 10'd0) && (vcount == 10'd0)});
      if (mdl_init) begin
        mdl_pal[mdl_cnt] = 6'(mdl_cnt);
        if (mdl_cnt == 15) mdl_init = 1'b0;
        mdl_cnt++;
      end else if (pal_wr_en) begin
        mdl_pal[pal_wr_addr] = pal_wr_data;
      end
      if (hcount == 10'd0 && vcount == 10'd480) begin
        if (sel_req < 2'd3) mdl_sel = int'(sel_req);
        else                mdl_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("pipe", 16'({red, green, blue, hsync_out, vsync_out, frame_start}), 16'(e));
    end
    check("ctrl", 16'({init_done, active_sel, sel_error}), 16'({!mdl_init, 2'(mdl_sel), mdl_err}));
  endtask

  task automatic px(input int h, input int v, input bit a);
    hcount = 10'(h);
    vcount = 10'(v);
    act    = a;
    cyc();
  endtask

  // Hold one pixel for two clocks; the output then shows that pixel.
  task automatic hold(input string tag, input int h, input int v, input bit a, input logic [5:0] exp);
    px(h, v, a);
    px(h, v, a);
    check(tag, 16'({red, green, blue}), 16'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; hcount = 10'd700; vcount = 10'd500; act = 1'b0;
    hs = 1'b1; vs = 1'b1; src_index = '0; src_valid = 3'b111; sel_req = '0;
    pal_wr_en = 1'b0; pal_wr_addr = '0; pal_wr_data = '0;
    border_en = 1'b0; border_color = '0;

    // Reset values
    cyc();
    check("rst_rgb", 16'({red, green, blue}), 16'h0);
    check("rst_sync", 16'({hsync_out, vsync_out}), 16'h3);
    check("rst_fs", 16'(frame_start), 16'h0);
    reset = 1'b0;

    // Init walk: 16 cycles, init_done visible on the 17th
    for (int i = 0; i < 15; i++) cyc();
    check("init_15", 16'(init_done), 16'h0);
    cyc();
    check("init_16", 16'(init_done), 16'h1);
    src_index = 12'h00F;
    hold("idx15", 10, 10, 1'b1, 6'b00_11_11);

    // Palette write then 2-cycle latency of colour and syncs
    pal_wr_en = 1'b1; pal_wr_addr = 4'd5; pal_wr_data = 6'h30;
    px(700, 10, 1'b0);
    pal_wr_en = 1'b0;
    src_index = 12'h005; hs = 1'b0;
    px(10, 10, 1'b1);
    check("lat1_rgb", 16'({red, green, blue}), 16'h0);
    check("lat1_hs", 16'(hsync_out), 16'h1);
    hs = 1'b1;
    px(11, 10, 1'b1);
    check("lat2_rgb", 16'({red, green, blue}), 16'({2'd3, 2'd0, 2'd0}));
    check("lat2_hs", 16'(hsync_out), 16'h0);
    vs = 1'b0;
    px(12, 10, 1'b1);
    vs = 1'b1;
    px(13, 10, 1'b1);
    check("vs_delay", 16'(vsync_out), 16'h0);
    px(14, 10, 1'b1);
    check("vs_back", 16'(vsync_out), 16'h1);

    // Source select only at vblank start; illegal request flags error
    src_index = 12'h0F5;
    sel_req = 2'd1;
    px(0, 100, 1'b0);
    px(5, 100, 1'b1);
    check("sel_hold", 16'(active_sel), 16'h0);
    hold("src0_shown", 20, 100, 1'b1, 6'h30);
    px(0, 480, 1'b0);
    check("sel_switch", 16'(active_sel), 16'h1);
    sel_req = 2'd0;
    hold("src1_shown", 20, 20, 1'b1, 6'h0F);
    sel_req = 2'd3;
    px(0, 480, 1'b0);
    check("sel_err", 16'(sel_error), 16'h1);
    check("sel_keep", 16'(active_sel), 16'h1);
    sel_req = 2'd0;
    px(0, 480, 1'b0);
    check("sel_back", 16'(active_sel), 16'h0);
    check("err_sticky", 16'(sel_error), 16'h1);

    // Debug border
    border_en = 1'b1; border_color = 6'h3F;
    hold("brd_h0", 0, 10, 1'b1, 6'h3F);
    hold("brd_h639", 639, 10, 1'b1, 6'h3F);
    hold("brd_v0", 10, 0, 1'b1, 6'h3F);
    hold("brd_v479", 10, 479, 1'b1, 6'h3F);
    hold("brd_inner", 10, 10, 1'b1, 6'h30);
    hold("brd_blank", 0, 10, 1'b0, 6'h00);
    hold("brd_00", 0, 0, 1'b1, 6'h3F);
    check("fs_00", 16'(frame_start), 16'h1);
    border_en = 1'b0;

    // Read-first palette and invalid source
    src_index = 12'h002;
    pal_wr_en = 1'b1; pal_wr_addr = 4'd2; pal_wr_data = 6'h2A;
    px(30, 30, 1'b1);
    pal_wr_en = 1'b0;
    px(31, 30, 1'b1);
    check("rdfirst_old", 16'({red, green, blue}), 16'h02);
    px(32, 30, 1'b1);
    check("rdfirst_new", 16'({red, green, blue}), 16'h2A);
    pal_wr_en = 1'b1; pal_wr_addr = 4'd0; pal_wr_data = 6'h15;
    px(700, 30, 1'b0);
    pal_wr_en = 1'b0;
    src_index = 12'h009; src_valid = 3'b110;
    hold("invalid_src", 40, 30, 1'b1, 6'h15);
    src_valid = 3'b111;

    // Reset mid-line in RUN, then reset again part-way through INIT
    pal_wr_en = 1'b1; pal_wr_addr = 4'd3; pal_wr_data = 6'h3F;
    px(700, 30, 1'b0);
    pal_wr_en = 1'b0;
    src_index = 12'h005; hs = 1'b0;
    px(50, 30, 1'b1);
    px(51, 30, 1'b1);
    check("pre_rst", 16'({red, green, blue, hsync_out}), 16'({6'h30, 1'b0}));
    reset = 1'b1;
    px(52, 30, 1'b1);
    check("rst_mid_rgb", 16'({red, green, blue}), 16'h0);
    check("rst_mid_sync", 16'({hsync_out, vsync_out}), 16'h3);
    check("rst_mid_done", 16'(init_done), 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) px(53 + i, 30, 1'b1);
    hs = 1'b1;
    reset = 1'b1;
    px(60, 30, 1'b1);
    reset = 1'b0;
    pal_wr_en = 1'b1; pal_wr_addr = 4'd4; pal_wr_data = 6'h3F;
    for (int i = 0; i < 15; i++) px(60, 30, 1'b1);
    pal_wr_en = 1'b0;
    check("reinit_15", 16'(init_done), 16'h0);
    px(60, 30, 1'b1);
    check("reinit_16", 16'(init_done), 16'h1);
    src_index = 12'h003;
    hold("reinit_idx3", 60, 30, 1'b1, 6'h03);
    src_index = 12'h004;
    hold("init_wr_ignored", 61, 30, 1'b1, 6'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
